fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 153 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-entry instruction fetch front end.
//
// Walks the PC through the I-cache. On a hit it moves the word into a
// one-deep output register for decode. On a miss it holds a line refill
// request until the memory acknowledges it. Branch redirects from execute
// take priority over every other event.
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   take_branch/branch_loc redirect request and target from execute
//   ready                 decode accepts the current output word
//   cache_hit/instr_from_cache  same-cycle I-cache lookup of pc_to_cache
//   mem_ack               refill-complete pulse
//   pc_to_cache           current fetch PC
//   mem_req/mem_addr      refill request (level) and line-aligned address
//   instr_to_decode/pc_to_decode/valid  registered output word
//   miss_count            saturating count of refills started
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned LINE_BYTES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        take_branch,
    input  logic [31:0] branch_loc,
    input  logic        ready,
    input  logic        cache_hit,
    input  logic [31:0] instr_from_cache,
    input  logic        mem_ack,
    output logic [31:0] pc_to_cache,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] instr_to_decode,
    output logic [31:0] pc_to_decode,
    output logic        valid,
    output logic [15:0] miss_count
);

    localparam logic [31:0] LINE_MASK = ~(32'(LINE_BYTES) - 32'd1);

    typedef enum logic [1:0] {
        RUN          = 2'd0,
        REFILL       = 2'd1,
        REFILL_FLUSH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] dpc_q, dpc_d;
    logic        valid_q, valid_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] miss_q, miss_d;

    logic        slot_free;
    logic [31:0] br_tgt;

    assign slot_free = !valid_q || ready;
    assign br_tgt    = {branch_loc[31:2], 2'b00};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        instr_d = instr_q;
        dpc_d   = dpc_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        miss_d  = miss_q;

        // A consumed word leaves unless something replaces it below.
        if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            RUN: begin
                if (take_branch) begin
                    pc_d    = br_tgt;
                    valid_d = 1'b0;
                end else if (cache_hit) begin
                    if (slot_free) begin
                        instr_d = instr_from_cache;
                        dpc_d   = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + 32'd4;
                    end
                end else begin
                    state_d = REFILL;
                    addr_d  = pc_q & LINE_MASK;
                    if (miss_q != 16'hFFFF) begin
                        miss_d = miss_q + 16'd1;
                    end
                end
            end
            REFILL, REFILL_FLUSH: begin
                // The refill in flight always completes; a redirect only
                // changes where fetch resumes once it does.
                if (take_branch) begin
                    valid_d = 1'b0;
                    if (mem_ack) begin
                        state_d = RUN;
                        pc_d    = br_tgt;
                    end else begin
                        state_d = REFILL_FLUSH;
                        tgt_d   = br_tgt;
                    end
                end else if (mem_ack) begin
                    state_d = RUN;
                    if (state_q == REFILL_FLUSH) begin
                        pc_d = tgt_q;
                    end
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            tgt_q   <= 32'd0;
            instr_q <= 32'd0;
            dpc_q   <= 32'd0;
            valid_q <= 1'b0;
            addr_q  <= 32'd0;
            miss_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            instr_q <= instr_d;
            dpc_q   <= dpc_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            miss_q  <= miss_d;
        end
    end

    // Derived from the state register so reset drops the request at once.
    assign mem_req         = (state_q != RUN);
    assign pc_to_cache     = pc_q;
    assign mem_addr        = addr_q;
    assign instr_to_decode = instr_q;
    assign pc_to_decode    = dpc_q;
    assign valid           = valid_q;
    assign miss_count      = miss_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios followed by
// randomized traffic against a transaction-level fetch model.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        take_branch = 1'b0;
    logic [31:0] branch_loc = 32'd0;
    logic        ready = 1'b0;
    logic        cache_hit = 1'b0;
    logic [31:0] instr_from_cache = 32'd0;
    logic        mem_ack = 1'b0;
    logic [31:0] pc_to_cache, mem_addr, instr_to_decode, pc_to_decode;
    logic        mem_req, valid;
    logic [15:0] miss_count;

    // Second instance: free-running hit stream from the top of the map.
    logic [31:0] w_pc, w_addr, w_instr, w_dpc;
    logic        w_req, w_valid;
    logic [15:0] w_miss;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(32'h0), .LINE_BYTES(16)) dut (
        .clk(clk), .reset(reset), .take_branch(take_branch),
        .branch_loc(branch_loc), .ready(ready), .cache_hit(cache_hit),
        .instr_from_cache(instr_from_cache), .mem_ack(mem_ack),
        .pc_to_cache(pc_to_cache), .mem_req(mem_req), .mem_addr(mem_addr),
        .instr_to_decode(instr_to_decode), .pc_to_decode(pc_to_decode),
        .valid(valid), .miss_count(miss_count)
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC), .LINE_BYTES(16)) u_wrap (
        .clk(clk), .reset(reset), .take_branch(1'b0),
        .branch_loc(32'd0), .ready(1'b1), .cache_hit(1'b1),
        .instr_from_cache(32'h1234_5678), .mem_ack(1'b0),
        .pc_to_cache(w_pc), .mem_req(w_req), .mem_addr(w_addr),
        .instr_to_decode(w_instr), .pc_to_decode(w_dpc),
        .valid(w_valid), .miss_count(w_miss)
    );

    // ---------------- reference model ----------------
    // Fetch is either streaming or waiting on a line; while waiting, an
    // optional redirect target is remembered for when the line arrives.
    logic [31:0] m_pc, m_ipc, m_instr, m_addr, m_tgt;
    logic        m_valid, m_waiting, m_redirected;
    logic [15:0] m_miss;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0000_5A5A;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_ipc = 0; m_instr = 0; m_addr = 0; m_tgt = 0;
        m_valid = 0; m_waiting = 0; m_redirected = 0; m_miss = 0;
    endtask

    task automatic model_step();
        logic [31:0] aligned;
        aligned = branch_loc & 32'hFFFF_FFFC;
        if (m_waiting) begin
            if (ready) m_valid = 0;
            if (take_branch) begin
                m_valid = 0;
                if (mem_ack) begin
                    m_waiting = 0; m_redirected = 0; m_pc = aligned;
                end else begin
                    m_redirected = 1; m_tgt = aligned;
                end
            end else if (mem_ack) begin
                if (m_redirected) m_pc = m_tgt;
                m_waiting = 0; m_redirected = 0;
            end
        end else if (take_branch) begin
            m_pc = aligned; m_valid = 0;
        end else if (cache_hit) begin
            if (!m_valid || ready) begin
                m_ipc = m_pc; m_instr = instr_from_cache; m_valid = 1;
                m_pc = m_pc + 4;
            end
        end else begin
            m_waiting = 1;
            m_addr = m_pc - (m_pc % 16);
            if (m_miss < 16'hFFFF) m_miss = m_miss + 1;
            if (ready) m_valid = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("pc_to_cache", pc_to_cache, m_pc);
        chk("mem_req", 32'(mem_req), 32'(m_waiting));
        chk("mem_addr", mem_addr, m_addr);
        chk("valid", 32'(valid), 32'(m_valid));
        chk("pc_to_decode", pc_to_decode, m_ipc);
        chk("instr_to_decode", instr_to_decode, m_instr);
        chk("miss_count", 32'(miss_count), 32'(m_miss));
    endtask

    // Apply one cycle of inputs, advance the model, clock, then check.
    task automatic cyc(input bit br, input logic [31:0] bl, input bit rdy,
                       input bit hit, input bit ack);
        take_branch = br; branch_loc = bl; ready = rdy;
        cache_hit = hit; mem_ack = ack;
        instr_from_cache = hit ? word_at(m_pc) : 32'hDEAD_BEEF;
        model_step();
        @(posedge clk); #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #3;
        check_all();
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    bit res [int unsigned];

    initial begin
        // Reset state
        do_reset();
        chk("wrap_reset_pc", w_pc, 32'hFFFF_FFFC);

        // Hit stream: decode sees 0x0, 0x4, 0x8
        cyc(0, 0, 1, 1, 0);
        chk("wrap_pc0", w_pc, 32'h0);
        chk("wrap_dpc0", w_dpc, 32'hFFFF_FFFC);
        cyc(0, 0, 1, 1, 0);
        chk("wrap_pc1", w_pc, 32'h4);
        chk("wrap_dpc1", w_dpc, 32'h0);
        cyc(0, 0, 1, 1, 0);
        chk("stream_pcd8", pc_to_decode, 32'h8);

        // Backpressure: three stalled cycles hold everything
        repeat (3) cyc(0, 0, 0, 1, 0);
        chk("stall_pc", pc_to_cache, 32'hC);
        chk("stall_pcd", pc_to_decode, 32'h8);
        repeat (6) cyc(0, 0, 1, 1, 0);
        chk("resume_pc", pc_to_cache, 32'h24);

        // Miss at 0x24
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 0);
        chk("miss_addr", mem_addr, 32'h20);
        chk("miss_cnt", 32'(miss_count), 32'd1);
        chk("miss_req", 32'(mem_req), 32'd1);
        cyc(0, 0, 1, 0, 1);
        cyc(0, 0, 1, 1, 0);
        chk("retry_pcd", pc_to_decode, 32'h24);

        // Redirects during refill: last one wins
        cyc(0, 0, 1, 0, 0);
        cyc(1, 32'h103, 1, 0, 0);
        cyc(1, 32'h200, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("flush_req", 32'(mem_req), 32'd1);
        cyc(0, 0, 1, 0, 1);
        chk("flush_pc", pc_to_cache, 32'h200);
        chk("flush_valid", 32'(valid), 32'd0);

        // Redirect coincident with ack
        cyc(0, 0, 1, 0, 0);
        cyc(1, 32'h100, 1, 0, 1);
        chk("brack_pc", pc_to_cache, 32'h100);

        // Asynchronous reset mid-refill
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("async_req", 32'(mem_req), 32'd0);
        chk("async_valid", 32'(valid), 32'd0);
        chk("async_pc", pc_to_cache, 32'h0);
        @(posedge clk); #1;
        check_all();
        reset = 1'b1;
        cyc(0, 0, 1, 1, 0);
        chk("after_reset_pcd", pc_to_decode, 32'h0);

        // Randomized traffic with a small resident-line cache model
        for (int i = 0; i < 4000; i++) begin
            bit br, rdy, hit, ack;
            logic [31:0] bl;
            br  = ($urandom_range(0, 15) == 0);
            bl  = $urandom_range(0, 511);
            rdy = ($urandom_range(0, 3) != 0);
            ack = 0;
            hit = $urandom_range(0, 1);
            if (m_waiting) begin
                ack = ($urandom_range(0, 3) == 0);
                if (ack) res[m_addr >> 4] = 1'b1;
            end else begin
                hit = res.exists(m_pc >> 4) && ($urandom_range(0, 15) != 0);
            end
            if ($urandom_range(0, 63) == 0) res.delete();
            cyc(br, bl, rdy, hit, ack);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
